// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro SEQ_DIV_EARLY_OUT_EN: special cases finish on the accept edge.
module seq_divider #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(n + 1);
  localparam logic [n-1:0] MIN_NEG = {1'b1, {(n-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [n-1:0]  q, r, d, a;
  logic          neg_q, neg_r;
  logic          dz, ovf;
  logic [CW-1:0] count;

  logic [n-1:0]  quo, rem;
  logic          dz_out;

  logic          a_neg, b_neg;
  logic [n-1:0]  a_abs, b_abs;
  logic          in_dz, in_ovf;
  logic          early;
  logic          last;
  logic [n:0]    r_sh;
  logic [n+1:0]  diff;
  logic          fits;

  always_comb begin
    a_neg  = is_signed & dividend[n-1];
    b_neg  = is_signed & divisor[n-1];
    a_abs  = a_neg ? -dividend : dividend;
    b_abs  = b_neg ? -divisor : divisor;
    in_dz  = (divisor == '0);
    in_ovf = is_signed && (dividend == MIN_NEG)
             && (divisor == '1);
  end

`ifdef SEQ_DIV_EARLY_OUT_EN
  assign early = in_dz | in_ovf;
`else
  assign early = 1'b0;
`endif

  assign last = (count == CW'(n - 1));

  // One restoring step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    r_sh = {r, q[n-1]};
    diff = {1'b0, r_sh} - {2'b00, d};
    fits = ~diff[n+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = early ? DONE : CALC;
      CALC: if (last)  state_nxt = FIX;
      FIX:             state_nxt = DONE;
      DONE:            state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      r      <= '0;
      d      <= '0;
      a      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
      count  <= '0;
      quo    <= '0;
      rem    <= '0;
      dz_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            q     <= a_abs;
            a     <= a_abs;
            d     <= b_abs;
            r     <= '0;
            count <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dz    <= in_dz;
            ovf   <= in_ovf;
`ifdef SEQ_DIV_EARLY_OUT_EN
            unique case (1'b1)
              in_dz: begin
                quo    <= '1;
                rem    <= dividend;
                dz_out <= 1'b1;
              end
              in_ovf: begin
                quo    <= dividend;
                rem    <= '0;
                dz_out <= 1'b0;
              end
              default: ;
            endcase
`endif
          end
        end
        CALC: begin
          q     <= {q[n-2:0], fits};
          r     <= fits ? diff[n-1:0] : r_sh[n-1:0];
          count <= count + 1'b1;
        end
        FIX: begin
          dz_out <= dz;
          // Special cases override whatever the iteration produced.
          unique case (1'b1)
            dz: begin
              quo <= '1;
              rem <= neg_r ? -a : a;
            end
            ovf: begin
              quo <= MIN_NEG;
              rem <= '0;
            end
            default: begin
              quo <= neg_q ? -q : q;
              rem <= neg_r ? -r : r;
            end
          endcase
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign quotient    = quo;
  assign remainder   = rem;
  assign div_by_zero = dz_out;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (n = 32).
// Expected latency follows SEQ_DIV_EARLY_OUT_EN when defined.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(.n(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    logic        special;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic special);
`ifdef SEQ_DIV_EARLY_OUT_EN
    return special ? 1 : 34;
`else
    return 34;
`endif
  endfunction

  // Accept on the next edge; lat counts edges from the accept edge (=1).
  task automatic do_op(input logic s, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    @(negedge clk);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  initial begin
    int lat;
    int dcnt;
    int ok;

    vecs[0]  = '{"u100/7",   1'b0, 32'd100, 32'd7,
                 32'd14, 32'd2, 1'b0, 1'b0};
    vecs[1]  = '{"s-7/2",    1'b1, 32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[2]  = '{"s7/-2",    1'b1, 32'd7, 32'hFFFFFFFE,
                 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0};
    vecs[3]  = '{"u5/0",     1'b0, 32'd5, 32'd0,
                 32'hFFFFFFFF, 32'd5, 1'b1, 1'b1};
    vecs[4]  = '{"s5/0",     1'b1, 32'd5, 32'd0,
                 32'hFFFFFFFF, 32'd5, 1'b1, 1'b1};
    vecs[5]  = '{"s-7/0",    1'b1, 32'hFFFFFFF9, 32'd0,
                 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b1};
    vecs[6]  = '{"sovf",     1'b1, 32'h80000000, 32'hFFFFFFFF,
                 32'h80000000, 32'd0, 1'b0, 1'b1};
    vecs[7]  = '{"umin/ff",  1'b0, 32'h80000000, 32'hFFFFFFFF,
                 32'd0, 32'h80000000, 1'b0, 1'b0};
    vecs[8]  = '{"s-100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
                 32'd14, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[9]  = '{"uff/1",    1'b0, 32'hFFFFFFFF, 32'd1,
                 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0};
    vecs[10] = '{"u3/10",    1'b0, 32'd3, 32'd10,
                 32'd0, 32'd3, 1'b0, 1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
      chk({vecs[i].name, "_lat"}, 32'(lat),
          32'(exp_lat(vecs[i].special)));
      chk({vecs[i].name, "_q"}, quotient, vecs[i].eq);
      chk({vecs[i].name, "_r"}, remainder, vecs[i].er);
      chk({vecs[i].name, "_dz"}, 32'(div_by_zero),
          32'(vecs[i].edz));
      chk({vecs[i].name, "_busy"}, 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_pulse"}, 32'(done), 32'd0);
      chk({vecs[i].name, "_idle"}, 32'(busy), 32'd0);
      chk({vecs[i].name, "_hold"}, quotient, vecs[i].eq);
    end

    // start during DONE must be ignored
    do_op(1'b0, 32'd50, 32'd5, lat);
    chk("dstart_q", quotient, 32'd10);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("dstart_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("dstart_stay", 32'(busy), 32'd0);

    // start while busy with new operands must be ignored
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dcnt  = 0;
    lat   = -1;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dcnt++;
        if (lat < 0) lat = c;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("busy_start_lat", 32'(lat), 32'd34);
    chk("busy_start_cnt", 32'(dcnt), 32'd1);
    chk("busy_start_q", quotient, 32'd14);
    chk("busy_start_r", remainder, 32'd2);

    // reset mid-operation
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_q", quotient, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) ok = 0;
    end
    chk("mid_rst_quiet", 32'(ok), 32'd1);
    do_op(1'b0, 32'hFFFFFFFF, 32'd1, lat);
    chk("post_rst_lat", 32'(lat), 32'd34);
    chk("post_rst_q", quotient, 32'hFFFFFFFF);
    chk("post_rst_r", remainder, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
